// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I control path: opcode constants, the
// multi-cycle FSM state encoding and the datapath mux/ALU select encodings.
package riscv_ctrl_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR_ADR = 4'd10,
    S_JUMP     = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // alu_src_a
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLD_PC = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // alu_op
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  // imm_src
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // result_src
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // States that drive mem_req and may stall on mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait timer: counts stalled request cycles and flags the cycle in
// which one more stall would exceed the MEM_TIMEOUT budget.
module ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit ENABLED = (MEM_TIMEOUT != 0);
  localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  // Clear on entry to a memory state, otherwise count stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (count_en) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // count_en already implies mem_ready=0, so a ready response never expires
  assign expired = ENABLED && count_en && (wait_cnt == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM. Moore outputs decoded from the state (FETCH
// additionally qualifies its register writes with mem_ready). Memory handshake:
// mem_req is held high in FETCH/MEMRD/MEMWR until a cycle with mem_ready=1, in
// which the transfer completes and the FSM advances; stalls are bounded by the
// wait timer. All control outputs are held at 0 while rst_n is low.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT   = 16,
  parameter bit SUPPORT_JUMPS = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             branch,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             bus_error,
  output logic             illegal_instr,
  output logic             trapped,
  output state_t           state_dbg
);

  state_t state, state_next;

  logic       mem_req_c, mem_we_c, adr_src_c, ir_write_c, pc_write_c;
  logic       reg_write_c, branch_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, alu_op_c, result_src_c;
  logic [2:0] imm_src_c;
  logic       set_bus_error, set_illegal;
  logic       expired, timer_clear, timer_count;
  logic       retire_c;

  // Stall counting derives from the state directly to keep it off the decode path
  assign timer_count = is_mem_state(state) && !mem_ready;
  assign timer_clear = (state_next != state) && is_mem_state(state_next);

  ctrl_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .count_en (timer_count),
    .expired  (expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next    = state;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    adr_src_c     = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    reg_write_c   = 1'b0;
    branch_c      = 1'b0;
    alu_src_a_c   = SRCA_PC;
    alu_src_b_c   = SRCB_RS2;
    alu_op_c      = ALU_ADD;
    imm_src_c     = IMM_I;
    result_src_c  = RES_ALUOUT;
    set_bus_error = 1'b0;
    set_illegal   = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c   = 1'b1;
          pc_write_c   = 1'b1;
          alu_src_a_c  = SRCA_PC;
          alu_src_b_c  = SRCB_FOUR;
          result_src_c = RES_ALURESULT;
          state_next   = S_DECODE;
        end else if (expired) begin
          set_bus_error = 1'b1;
          state_next    = S_TRAP;
        end
      end

      S_DECODE: begin
        // Branch/JAL target computed here while the opcode is decoded
        alu_src_a_c = SRCA_OLD_PC;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = SUPPORT_JUMPS ? S_JUMP     : S_TRAP;
          OP_JALR:           state_next = SUPPORT_JUMPS ? S_JALR_ADR : S_TRAP;
          OP_LUI:            state_next = SUPPORT_JUMPS ? S_LUI      : S_TRAP;
          OP_AUIPC:          state_next = SUPPORT_JUMPS ? S_AUIPC    : S_TRAP;
          default:           state_next = S_TRAP;
        endcase
        set_illegal = (state_next == S_TRAP);
      end

      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        if (opcode == OP_STORE) begin
          imm_src_c  = IMM_S;
          state_next = S_MEMWR;
        end else begin
          imm_src_c  = IMM_I;
          state_next = S_MEMRD;
        end
      end

      S_MEMRD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (expired) begin
          set_bus_error = 1'b1;
          state_next    = S_TRAP;
        end
      end

      S_MEMWB: begin
        result_src_c = RES_MEMDATA;
        reg_write_c  = 1'b1;
        state_next   = S_FETCH;
      end

      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (expired) begin
          set_bus_error = 1'b1;
          state_next    = S_TRAP;
        end
      end

      S_EXEC_R: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        alu_op_c    = ALU_RFUNCT;
        state_next  = S_ALUWB;
      end

      S_EXEC_I: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALU_IFUNCT;
        state_next  = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write_c  = 1'b1;
        result_src_c = RES_ALUOUT;
        state_next   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a_c  = SRCA_RS1;
        alu_src_b_c  = SRCB_RS2;
        alu_op_c     = ALU_BRANCH;
        result_src_c = RES_ALUOUT;
        branch_c     = 1'b1;
        state_next   = S_FETCH;
      end

      S_JALR_ADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_I;
        state_next  = S_JUMP;
      end

      S_JUMP: begin
        // PC takes the target held in alu_out; ALU forms the link value
        alu_src_a_c  = SRCA_OLD_PC;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALUOUT;
        pc_write_c   = 1'b1;
        state_next   = S_ALUWB;
      end

      S_LUI: begin
        alu_src_a_c = SRCA_ZERO;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_U;
        state_next  = S_ALUWB;
      end

      S_AUIPC: begin
        alu_src_a_c = SRCA_OLD_PC;
        alu_src_b_c = SRCB_IMM;
        imm_src_c   = IMM_U;
        state_next  = S_ALUWB;
      end

      S_TRAP: begin
        state_next = S_TRAP;
      end

      default: begin
        state_next = S_TRAP;
      end
    endcase
  end

  // Completion is any transition back into FETCH
  assign retire_c = (state_next == S_FETCH) && (state != S_FETCH);

  // Sticky trap causes and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_error     <= 1'b0;
      illegal_instr <= 1'b0;
      instret       <= '0;
    end else begin
      if (set_bus_error) bus_error <= 1'b1;
      if (set_illegal) illegal_instr <= 1'b1;
      if (retire_c) instret <= instret + CNT_W'(1);
    end
  end

  // Control outputs are forced low while reset is asserted
  assign mem_req    = rst_n & mem_req_c;
  assign mem_we     = rst_n & mem_we_c;
  assign adr_src    = rst_n & adr_src_c;
  assign ir_write   = rst_n & ir_write_c;
  assign pc_write   = rst_n & pc_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign branch     = rst_n & branch_c;
  assign alu_src_a  = rst_n ? alu_src_a_c  : 2'b00;
  assign alu_src_b  = rst_n ? alu_src_b_c  : 2'b00;
  assign alu_op     = rst_n ? alu_op_c     : 2'b00;
  assign imm_src    = rst_n ? imm_src_c    : 3'b000;
  assign result_src = rst_n ? result_src_c : 2'b00;
  assign retire     = rst_n & retire_c;
  assign trapped    = rst_n & (state == S_TRAP);
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Main instance: MEM_TIMEOUT=4,
// jumps enabled, 4-bit instret. Second instance shares all inputs and runs with
// the timeout disabled and jumps unsupported.
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;

  // Control vector field order:
  // mem_req,mem_we,adr_src,ir_write,pc_write,reg_write,branch,a[2],b[2],alu_op[2],imm[3],result[2],retire
  localparam logic [31:0] C_ZERO       = 32'(19'b0_0_0_0_0_0_0_00_00_00_000_00_0);
  localparam logic [31:0] C_FETCH_RDY  = 32'(19'b1_0_0_1_1_0_0_00_10_00_000_10_0);
  localparam logic [31:0] C_FETCH_WAIT = 32'(19'b1_0_0_0_0_0_0_00_00_00_000_00_0);
  localparam logic [31:0] C_DECODE     = 32'(19'b0_0_0_0_0_0_0_01_01_00_010_00_0);
  localparam logic [31:0] C_EXEC_R     = 32'(19'b0_0_0_0_0_0_0_10_00_10_000_00_0);
  localparam logic [31:0] C_EXEC_I     = 32'(19'b0_0_0_0_0_0_0_10_01_11_000_00_0);
  localparam logic [31:0] C_ALUWB      = 32'(19'b0_0_0_0_0_1_0_00_00_00_000_00_1);
  localparam logic [31:0] C_MEMADR_LD  = 32'(19'b0_0_0_0_0_0_0_10_01_00_000_00_0);
  localparam logic [31:0] C_MEMADR_ST  = 32'(19'b0_0_0_0_0_0_0_10_01_00_001_00_0);
  localparam logic [31:0] C_MEMRD      = 32'(19'b1_0_1_0_0_0_0_00_00_00_000_00_0);
  localparam logic [31:0] C_MEMWB      = 32'(19'b0_0_0_0_0_1_0_00_00_00_000_01_1);
  localparam logic [31:0] C_MEMWR_RDY  = 32'(19'b1_1_1_0_0_0_0_00_00_00_000_00_1);
  localparam logic [31:0] C_BRANCH     = 32'(19'b0_0_0_0_0_0_1_10_00_01_000_00_1);
  localparam logic [31:0] C_JALR_ADR   = 32'(19'b0_0_0_0_0_0_0_10_01_00_000_00_0);
  localparam logic [31:0] C_JUMP       = 32'(19'b0_0_0_0_1_0_0_01_10_00_000_00_0);
  localparam logic [31:0] C_LUI        = 32'(19'b0_0_0_0_0_0_0_11_01_00_100_00_0);
  localparam logic [31:0] C_AUIPC      = 32'(19'b0_0_0_0_0_0_0_01_01_00_100_00_0);

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;

  // Main instance outputs
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, branch;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0] imm_src;
  logic       retire, bus_error, illegal_instr, trapped;
  logic [3:0] instret;
  state_t     state_dbg;

  // Second instance outputs
  logic        n_mem_req, n_mem_we, n_adr_src, n_ir_write, n_pc_write, n_reg_write, n_branch;
  logic [1:0]  n_alu_src_a, n_alu_src_b, n_alu_op, n_result_src;
  logic [2:0]  n_imm_src;
  logic        n_retire, n_bus_error, n_illegal_instr, n_trapped;
  logic [31:0] n_instret;
  state_t      n_state_dbg;

  int total = 0;
  int bad   = 0;

  logic [3:0]  exp_q[$];
  logic [31:0] obs[0:31];
  logic [3:0]  st2[0:31];

  multicycle_control_unit #(
    .MEM_TIMEOUT (4),
    .SUPPORT_JUMPS (1'b1),
    .CNT_W (4)
  ) dut (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .mem_ready (mem_ready),
    .mem_req (mem_req), .mem_we (mem_we), .adr_src (adr_src),
    .ir_write (ir_write), .pc_write (pc_write), .reg_write (reg_write),
    .branch (branch), .alu_src_a (alu_src_a), .alu_src_b (alu_src_b),
    .alu_op (alu_op), .imm_src (imm_src), .result_src (result_src),
    .retire (retire), .instret (instret), .bus_error (bus_error),
    .illegal_instr (illegal_instr), .trapped (trapped), .state_dbg (state_dbg)
  );

  multicycle_control_unit #(
    .MEM_TIMEOUT (0),
    .SUPPORT_JUMPS (1'b0),
    .CNT_W (32)
  ) dut_nj (
    .clk (clk), .rst_n (rst_n), .opcode (opcode), .mem_ready (mem_ready),
    .mem_req (n_mem_req), .mem_we (n_mem_we), .adr_src (n_adr_src),
    .ir_write (n_ir_write), .pc_write (n_pc_write), .reg_write (n_reg_write),
    .branch (n_branch), .alu_src_a (n_alu_src_a), .alu_src_b (n_alu_src_b),
    .alu_op (n_alu_op), .imm_src (n_imm_src), .result_src (n_result_src),
    .retire (n_retire), .instret (n_instret), .bus_error (n_bus_error),
    .illegal_instr (n_illegal_instr), .trapped (n_trapped), .state_dbg (n_state_dbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cur_ctl();
    return 32'({mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, branch,
                alu_src_a, alu_src_b, alu_op, imm_src, result_src, retire});
  endfunction

  // Holds reset for two edges, releases just after a rising edge
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drives one instruction; exp_q holds the expected state of every cycle.
  // fetch_wait / mem_wait are stall cycles before mem_ready in FETCH / MEMRD-MEMWR.
  task automatic run_seq(input logic [6:0] op, input int fetch_wait, input int mem_wait);
    int fw;
    int mw;
    int i;
    logic [3:0] e;
    fw = fetch_wait;
    mw = mem_wait;
    i  = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      opcode = op;
      if (e == S_FETCH) begin
        mem_ready = (fw == 0);
        if (fw > 0) fw--;
      end else if (e == S_MEMRD || e == S_MEMWR) begin
        mem_ready = (mw == 0);
        if (mw > 0) mw--;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      obs[i] = cur_ctl();
      st2[i] = n_state_dbg;
      check($sformatf("state[%0d] op=%b", i, op), 32'(state_dbg), 32'(e));
      i++;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic push3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = OP_RTYPE;

    // Reset: state FETCH but every control output held low
    @(negedge clk);
    check("rst_ctl", cur_ctl(), C_ZERO);
    check("rst_state", 32'(state_dbg), 32'(S_FETCH));
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_trapped", 32'(trapped), 32'd0);
    check("rst_flags", 32'({bus_error, illegal_instr}), 32'd0);
    do_reset();

    // R-type, zero wait: 4 cycles
    push3(S_FETCH, S_DECODE, S_EXEC_R);
    exp_q.push_back(S_ALUWB);
    run_seq(OP_RTYPE, 0, 0);
    check("r_fetch", obs[0], C_FETCH_RDY);
    check("r_decode", obs[1], C_DECODE);
    check("r_exec", obs[2], C_EXEC_R);
    check("r_aluwb", obs[3], C_ALUWB);
    check("r_instret", 32'(instret), 32'd1);
    check("r_back_fetch", 32'(state_dbg), 32'(S_FETCH));

    // Load, MEMRD stalls 3 cycles (ready on the last timer cycle): 8 cycles
    push3(S_FETCH, S_DECODE, S_MEMADR);
    repeat (4) exp_q.push_back(S_MEMRD);
    exp_q.push_back(S_MEMWB);
    run_seq(OP_LOAD, 0, 3);
    check("ld_memadr", obs[2], C_MEMADR_LD);
    check("ld_memrd_wait", obs[3], C_MEMRD);
    check("ld_memrd_rdy", obs[6], C_MEMRD);
    check("ld_memwb", obs[7], C_MEMWB);
    check("ld_instret", 32'(instret), 32'd2);
    check("ld_bus_error", 32'(bus_error), 32'd0);

    // Store: 4 cycles
    push3(S_FETCH, S_DECODE, S_MEMADR);
    exp_q.push_back(S_MEMWR);
    run_seq(OP_STORE, 0, 0);
    check("st_memadr", obs[2], C_MEMADR_ST);
    check("st_memwr", obs[3], C_MEMWR_RDY);
    check("st_instret", 32'(instret), 32'd3);

    // I-type
    push3(S_FETCH, S_DECODE, S_EXEC_I);
    exp_q.push_back(S_ALUWB);
    run_seq(OP_ITYPE, 0, 0);
    check("i_exec", obs[2], C_EXEC_I);
    check("i_aluwb", obs[3], C_ALUWB);

    // Branch: 3 cycles
    push3(S_FETCH, S_DECODE, S_BRANCH);
    run_seq(OP_BRANCH, 0, 0);
    check("br_branch", obs[2], C_BRANCH);
    check("br_instret", 32'(instret), 32'd5);
    check("nj_instret5", n_instret, 32'd5);

    // LUI: legal on main, illegal on the no-jumps instance
    push3(S_FETCH, S_DECODE, S_LUI);
    exp_q.push_back(S_ALUWB);
    run_seq(OP_LUI, 0, 0);
    check("lui_lui", obs[2], C_LUI);
    check("nj_lui_trap", 32'(st2[2]), 32'(S_TRAP));
    check("nj_lui_illegal", 32'(n_illegal_instr), 32'd1);

    // AUIPC
    push3(S_FETCH, S_DECODE, S_AUIPC);
    exp_q.push_back(S_ALUWB);
    run_seq(OP_AUIPC, 0, 0);
    check("auipc_auipc", obs[2], C_AUIPC);
    check("auipc_instret", 32'(instret), 32'd7);
    check("main_no_illegal", 32'(illegal_instr), 32'd0);

    // JALR: 5 cycles
    do_reset();
    push3(S_FETCH, S_DECODE, S_JALR_ADR);
    exp_q.push_back(S_JUMP);
    exp_q.push_back(S_ALUWB);
    run_seq(OP_JALR, 0, 0);
    check("jalr_adr", obs[2], C_JALR_ADR);
    check("jalr_jump", obs[3], C_JUMP);
    check("jalr_aluwb", obs[4], C_ALUWB);
    check("jalr_instret", 32'(instret), 32'd1);
    check("nj_jalr_trap", 32'(st2[2]), 32'(S_TRAP));

    // JAL: legal on main (4 cycles), illegal with jumps unsupported
    do_reset();
    push3(S_FETCH, S_DECODE, S_JUMP);
    exp_q.push_back(S_ALUWB);
    run_seq(OP_JAL, 0, 0);
    check("jal_jump", obs[2], C_JUMP);
    check("jal_instret", 32'(instret), 32'd1);
    check("nj_jal_decode", 32'(st2[1]), 32'(S_DECODE));
    check("nj_jal_trap", 32'(st2[2]), 32'(S_TRAP));
    check("nj_jal_flags", 32'({n_illegal_instr, n_bus_error, n_trapped}), 32'b101);
    check("nj_jal_instret", n_instret, 32'd0);

    // Unknown opcode: both instances trap, outputs all zero in TRAP
    do_reset();
    push3(S_FETCH, S_DECODE, S_TRAP);
    exp_q.push_back(S_TRAP);
    run_seq(7'b1111111, 0, 0);
    check("ill_trap_ctl", obs[3], C_ZERO);
    check("ill_flags", 32'({illegal_instr, bus_error, trapped}), 32'b101);
    check("ill_instret", 32'(instret), 32'd0);
    check("nj_ill_trap", 32'(st2[2]), 32'(S_TRAP));
    check("nj_ill_illegal", 32'(n_illegal_instr), 32'd1);

    // FETCH timeout: 4 stalled cycles then TRAP, absorbing
    do_reset();
    repeat (4) exp_q.push_back(S_FETCH);
    repeat (3) exp_q.push_back(S_TRAP);
    run_seq(OP_RTYPE, 100, 0);
    check("to_fetch_wait", obs[0], C_FETCH_WAIT);
    check("to_trap_ctl", obs[4], C_ZERO);
    check("to_flags", 32'({bus_error, illegal_instr, trapped}), 32'b101);
    check("nj_no_timeout", 32'(st2[6]), 32'(S_FETCH));
    check("nj_no_bus_error", 32'(n_bus_error), 32'd0);

    // Ready on the 4th FETCH cycle wins over the timeout
    do_reset();
    repeat (4) exp_q.push_back(S_FETCH);
    push3(S_DECODE, S_EXEC_R, S_ALUWB);
    run_seq(OP_RTYPE, 3, 0);
    check("to_edge_fetch", obs[3], C_FETCH_RDY);
    check("to_edge_bus_error", 32'(bus_error), 32'd0);
    check("to_edge_instret", 32'(instret), 32'd1);

    // MEMRD timeout: 4 stalled cycles then TRAP
    push3(S_FETCH, S_DECODE, S_MEMADR);
    repeat (4) exp_q.push_back(S_MEMRD);
    exp_q.push_back(S_TRAP);
    run_seq(OP_LOAD, 0, 100);
    check("memrd_to_bus_error", 32'(bus_error), 32'd1);
    check("memrd_to_trapped", 32'(trapped), 32'd1);

    // 17 retirements: 4-bit counter wraps to 1
    do_reset();
    for (int k = 0; k < 17; k++) begin
      push3(S_FETCH, S_DECODE, S_BRANCH);
      run_seq(OP_BRANCH, 0, 0);
    end
    check("wrap_instret", 32'(instret), 32'd1);
    check("nj_wrap_instret", n_instret, 32'd17);

    // Reset asserted mid-MEMWR: outputs drop at once, FETCH after release
    do_reset();
    push3(S_FETCH, S_DECODE, S_MEMADR);
    run_seq(OP_STORE, 0, 0);
    @(negedge clk);
    check("mw_in_memwr", 32'(state_dbg), 32'(S_MEMWR));
    check("mw_we_high", 32'(mem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mw_rst_ctl", cur_ctl(), C_ZERO);
    check("mw_rst_state", 32'(state_dbg), 32'(S_FETCH));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mw_after_state", 32'(state_dbg), 32'(S_FETCH));
    check("mw_after_ctl", cur_ctl(), C_FETCH_WAIT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
